// File: rtl/matvec8_pkg.sv
// matvec8_pkg: shared sizes and FSM state encodings for the 8x8 matrix-vector engine
package matvec8_pkg;
  localparam int K = 8;
  localparam int IW = 14;
  localparam int OW = 28;
  localparam int MCW = 6;
  localparam int CCW = 4;
  localparam int ICW = 3;
  typedef logic [2:0] state_t;
  localparam state_t IDLE = 3'd0;
  localparam state_t LOAD_M = 3'd1;
  localparam state_t LOAD_X = 3'd2;
  localparam state_t COMPUTE = 3'd3;
  localparam state_t OUT = 3'd4;
endpackage

// File: rtl/matvec8_mac_lane.sv
// matvec8_mac_lane: one MAC lane, registered product then wrapping accumulate
//   clk, reset  clock, async active-high reset
//   clr         zero the accumulator (wins over en_acc)
//   en_p        register a*b into the product stage
//   en_acc      add the product stage into the accumulator
//   a, b        signed operands; acc is the signed running sum mod 2^OW
module matvec8_mac_lane
  import matvec8_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 en_p,
  input  logic                 en_acc,
  input  logic signed [IW-1:0] a,
  input  logic signed [IW-1:0] b,
  output logic signed [OW-1:0] acc
);
  logic signed [OW-1:0] p;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      p <= '0;
      acc <= '0;
    end else begin
      if (en_p) p <= OW'(a) * OW'(b);
      if (clr) acc <= '0;
      else if (en_acc) acc <= acc + p;
    end
endmodule

// File: rtl/matvec8_part4.sv
// matvec8_part4: streaming 8x8 signed matrix-vector multiplier y = M*x with 8 MAC lanes
//   clk, reset                      clock, async active-high reset
//   input_valid/ready/data          input stream: optional 64-word matrix then 8-word vector
//   new_matrix                      sampled with the first word; 1 = matrix precedes vector
//   output_valid/ready/data         result stream y[0]..y[7]
module matvec8_part4
  import matvec8_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          input_valid,
  output logic          input_ready,
  input  logic [IW-1:0] input_data,
  input  logic          new_matrix,
  output logic          output_valid,
  input  logic          output_ready,
  output logic [OW-1:0] output_data
);
  state_t state;
  logic [MCW-1:0] cnt;
  logic [CCW-1:0] ccnt;
  logic [ICW-1:0] idx;
  logic signed [IW-1:0] m [K*K];
  logic signed [IW-1:0] x [K];
  logic signed [OW-1:0] acc [K];
  logic in_xfer, out_xfer, clr, en_p, en_acc;
  assign in_xfer = input_valid & input_ready;
  assign out_xfer = output_valid & output_ready;
  assign clr = state == LOAD_X && in_xfer && cnt == MCW'(7);
  // compute step ccnt issues column ccnt (0..7) and accumulates column ccnt-1 (1..8);
  // step 9 only moves the first result into the output register
  assign en_p = state == COMPUTE && !ccnt[3];
  assign en_acc = state == COMPUTE && ccnt != '0 && ccnt <= CCW'(8);
  for (genvar r = 0; r < K; r++) begin : g_lane
    matvec8_mac_lane u_lane (
      .clk(clk),
      .reset(reset),
      .clr(clr),
      .en_p(en_p),
      .en_acc(en_acc),
      .a(m[{3'(r), ccnt[2:0]}]),
      .b(x[ccnt[2:0]]),
      .acc(acc[r])
    );
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      ccnt <= '0;
      idx <= '0;
      input_ready <= 1'b0;
      output_valid <= 1'b0;
      output_data <= '0;
      for (int i = 0; i < K*K; i++) m[i] <= '0;
      for (int i = 0; i < K; i++) x[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          input_ready <= 1'b1;
          if (in_xfer) begin
            cnt <= MCW'(1);
            if (new_matrix) begin
              m[0] <= input_data;
              state <= LOAD_M;
            end else begin
              x[0] <= input_data;
              state <= LOAD_X;
            end
          end
        end
        LOAD_M: if (in_xfer) begin
          m[cnt] <= input_data;
          cnt <= cnt + 1'b1;
          if (cnt == '1) state <= LOAD_X;
        end
        LOAD_X: if (in_xfer) begin
          x[cnt[2:0]] <= input_data;
          cnt <= cnt + 1'b1;
          if (cnt == MCW'(7)) begin
            cnt <= '0;
            ccnt <= '0;
            input_ready <= 1'b0;
            state <= COMPUTE;
          end
        end
        COMPUTE: begin
          ccnt <= ccnt + 1'b1;
          if (ccnt == CCW'(9)) begin
            ccnt <= '0;
            idx <= '0;
            output_valid <= 1'b1;
            output_data <= acc[0];
            state <= OUT;
          end
        end
        OUT: if (out_xfer) begin
          if (idx == '1) begin
            output_valid <= 1'b0;
            input_ready <= 1'b1;
            state <= IDLE;
          end else begin
            idx <= idx + 1'b1;
            output_data <= acc[idx + 1'b1];
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_matvec8_part4.sv
// tb_matvec8_part4: randomized self-checking bench for matvec8_part4 against a y = M*x model
module tb_matvec8_part4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic input_valid = 1'b0;
  logic input_ready;
  logic [13:0] input_data = '0;
  logic new_matrix = 1'b0;
  logic output_valid;
  logic output_ready = 1'b0;
  logic [27:0] output_data;
  int errors = 0;
  int checks = 0;
  int mm [64];
  int xv [8];
  logic [27:0] ey [8];

  matvec8_part4 dut (
    .clk(clk),
    .reset(reset),
    .input_valid(input_valid),
    .input_ready(input_ready),
    .input_data(input_data),
    .new_matrix(new_matrix),
    .output_valid(output_valid),
    .output_ready(output_ready),
    .output_data(output_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int rnd14();
    logic [13:0] v;
    v = 14'($urandom);
    return int'($signed(v));
  endfunction

  function automatic void model();
    for (int r = 0; r < 8; r++) begin
      longint s = 0;
      for (int c = 0; c < 8; c++) s += longint'(mm[r*8+c]) * longint'(xv[c]);
      ey[r] = 28'(s);
    end
  endfunction

  task automatic send(input bit nm, input bit rv);
    int words[$];
    int k = 0;
    int guard = 0;
    int lat = 0;
    if (nm) foreach (mm[i]) words.push_back(mm[i]);
    foreach (xv[i]) words.push_back(xv[i]);
    while (k < words.size()) begin
      @(negedge clk);
      input_valid = rv ? ($urandom_range(0, 3) != 0) : 1'b1;
      input_data = 14'(words[k]);
      new_matrix = (k == 0) ? nm : 1'($urandom);
      if (input_valid && input_ready) k++;
      if (++guard > 5000) begin
        chk("send_timeout", 32'(k), 32'(words.size()));
        break;
      end
    end
    @(posedge clk);
    #1 input_valid = 1'b0;
    chk("ready_low_after_x7", 32'(input_ready), 0);
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!output_valid && lat < 50);
    chk("latency", 32'(lat), 10);
  endtask

  task automatic recv(input int mode);
    int i = 0;
    int stall = 0;
    int guard = 0;
    bit held = 0;
    logic [27:0] last = '0;
    model();
    while (i < 8) begin
      @(negedge clk);
      if (held) begin
        chk("hold_data", 32'(output_data), 32'(last));
        chk("hold_valid", 32'(output_valid), 1);
      end
      if (mode == 0) output_ready = 1'b1;
      else if (mode == 1) output_ready = 1'($urandom);
      else begin
        output_ready = !(i == 2 && stall < 5);
        if (!output_ready) stall++;
      end
      if (output_valid && output_ready) begin
        chk($sformatf("y%0d", i), 32'(output_data), 32'(ey[i]));
        i++;
        held = 0;
      end else begin
        held = output_valid;
        last = output_data;
      end
      if (++guard > 5000) begin
        chk("recv_timeout", 32'(i), 8);
        break;
      end
    end
    @(posedge clk);
    #1 output_ready = 1'b0;
    chk("valid_drop", 32'(output_valid), 0);
  endtask

  initial begin
    #1;
    chk("rst_valid", 32'(output_valid), 0);
    chk("rst_ready", 32'(input_ready), 0);
    chk("rst_data", 32'(output_data), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    foreach (mm[i]) mm[i] = 0;
    for (int r = 0; r < 8; r++) mm[r*8+r] = 1;
    foreach (xv[i]) xv[i] = i + 1;
    send(1, 0);
    recv(0);
    foreach (xv[i]) xv[i] = 2;
    send(0, 0);
    recv(0);
    foreach (mm[i]) mm[i] = -8192;
    foreach (xv[i]) xv[i] = -8192;
    send(1, 0);
    recv(0);
    foreach (mm[i]) mm[i] = 8191;
    send(1, 0);
    recv(0);
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) mm[r*8+c] = r + c;
    foreach (xv[i]) xv[i] = 1;
    send(1, 0);
    recv(2);
    foreach (mm[i]) mm[i] = rnd14();
    foreach (xv[i]) xv[i] = rnd14();
    send(1, 0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_valid", 32'(output_valid), 0);
    chk("midrst_ready", 32'(input_ready), 0);
    @(negedge clk);
    reset = 1'b0;
    foreach (mm[i]) mm[i] = 0;
    foreach (xv[i]) xv[i] = rnd14();
    send(0, 1);
    recv(0);
    for (int t = 0; t < 1000; t++) begin
      bit nm;
      nm = ($urandom_range(0, 7) == 0);
      if (nm) foreach (mm[i]) mm[i] = rnd14();
      foreach (xv[i]) xv[i] = rnd14();
      send(nm, 1);
      recv(1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
